// File: rtl/cdb_arbiter_n.sv
// Common data bus arbiter: per-source result FIFOs feeding one registered CDB
// broadcast per cycle, with round-robin or fixed-priority selection and flush.
module cdb_arbiter_n #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int ARB_MODE   = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush,
  input  logic [NUM_SRC-1:0]                         src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]                   src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]                  src_data,
  output logic [NUM_SRC-1:0]                         src_ready,
  output logic                                       cdb_valid,
  output logic [TAG_W-1:0]                           cdb_tag,
  output logic [DATA_W-1:0]                          cdb_data,
  output logic [$clog2(NUM_SRC)-1:0]                 cdb_src,
  output logic [NUM_SRC*$clog2(FIFO_DEPTH+1)-1:0]    src_count
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = TAG_W + DATA_W;

  typedef logic [ENT_W-1:0] ent_t;

  ent_t             mem_q    [NUM_SRC][FIFO_DEPTH];
  logic [CNT_W-1:0] count_q  [NUM_SRC];
  logic [CNT_W-1:0] count_d  [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_d [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr_d [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SRC_W-1:0]  cdb_src_q;

  logic [NUM_SRC-1:0] push, pop;
  logic               gnt_vld;
  logic [SRC_W-1:0]   gnt_idx;
  ent_t               head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration over non-empty FIFO heads
  always_comb begin : arb
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (ARB_MODE == 0) ? (int'(rr_ptr_q) + k) % NUM_SRC : k;
      if (!gnt_vld && count_q[idx] != '0) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

  assign head = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];

  // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (count_q[i] < CNT_W'(FIFO_DEPTH)) && !flush;
      push[i]      = src_valid[i] && src_ready[i];
      pop[i]       = gnt_vld && (gnt_idx == SRC_W'(i)) && !flush;
      count_d[i]   = count_q[i];
      rd_ptr_d[i]  = rd_ptr_q[i];
      wr_ptr_d[i]  = wr_ptr_q[i];
      if (push[i] && !pop[i])      count_d[i] = count_q[i] + 1'b1;
      else if (pop[i] && !push[i]) count_d[i] = count_q[i] - 1'b1;
      if (push[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      if (pop[i])  rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      if (flush) begin
        count_d[i]  = '0;
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (ARB_MODE == 0 && gnt_vld && !flush)
      rr_ptr_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count_q[i]  <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= gnt_vld && !flush;
      if (gnt_vld && !flush) begin
        {cdb_tag_q, cdb_data_q} <= head;
        cdb_src_q               <= gnt_idx;
      end
    end
  end

  // FIFO storage is never cleared; occupancy and pointers define what is live
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (push[i])
        mem_q[i][wr_ptr_q[i]] <= {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
  end

  always_comb begin
    src_count = '0;
    for (int i = 0; i < NUM_SRC; i++)
      src_count[i*CNT_W +: CNT_W] = count_q[i];
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter_n.sv
// Bench for cdb_arbiter_n: a round-robin and a fixed-priority instance share
// the stimulus and are checked against a queue-based model of the arbiter.
module tb_cdb_arbiter_n;
  localparam int NS = 2, DW = 16, TW = 3, FD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, flush = 1'b0;
  logic [NS-1:0]     src_valid = '0;
  logic [NS*TW-1:0]  src_tag   = '0;
  logic [NS*DW-1:0]  src_data  = '0;

  logic [1:0]  r_ready, f_ready;
  logic        r_cv, f_cv;
  logic [2:0]  r_tag, f_tag;
  logic [15:0] r_data, f_data;
  logic        r_src, f_src;
  logic [3:0]  r_cnt, f_cnt;

  int n_tests = 0, n_fail = 0;

  cdb_arbiter_n #(.NUM_SRC(NS), .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(FD), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .flush(flush), .src_valid(src_valid), .src_tag(src_tag),
    .src_data(src_data), .src_ready(r_ready), .cdb_valid(r_cv), .cdb_tag(r_tag),
    .cdb_data(r_data), .cdb_src(r_src), .src_count(r_cnt));

  cdb_arbiter_n #(.NUM_SRC(NS), .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(FD), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .flush(flush), .src_valid(src_valid), .src_tag(src_tag),
    .src_data(src_data), .src_ready(f_ready), .cdb_valid(f_cv), .cdb_tag(f_tag),
    .cdb_data(f_data), .cdb_src(f_src), .src_count(f_cnt));

  // Reference model: index 2*m+i is source i of instance m (0 = RR, 1 = FP)
  logic [18:0] mq [4][$];
  int          m_rr  [2];
  logic        m_cv  [2];
  logic [2:0]  m_tag [2];
  logic [15:0] m_data[2];
  logic        m_src [2];

  always @(posedge clk) begin : model
    int w, s, b;
    bit acc [2];
    for (int m = 0; m < 2; m++) begin
      b = 2 * m;
      if (rst) begin
        mq[b].delete(); mq[b+1].delete();
        m_rr[m] = 0; m_cv[m] = 1'b0; m_tag[m] = '0; m_data[m] = '0; m_src[m] = 1'b0;
      end else if (flush) begin
        mq[b].delete(); mq[b+1].delete();
        m_cv[m] = 1'b0;
      end else begin
        for (int i = 0; i < NS; i++) acc[i] = src_valid[i] && (mq[b+i].size() < FD);
        w = -1;
        for (int k = 0; k < NS; k++) begin
          s = (m == 0) ? (m_rr[m] + k) % NS : k;
          if (w < 0 && mq[b+s].size() > 0) w = s;
        end
        if (w >= 0) begin
          {m_tag[m], m_data[m]} = mq[b+w].pop_front();
          m_cv[m]  = 1'b1;
          m_src[m] = w[0];
          if (m == 0) m_rr[m] = (w + 1) % NS;
        end else begin
          m_cv[m] = 1'b0;
        end
        for (int i = 0; i < NS; i++)
          if (acc[i]) mq[b+i].push_back({src_tag[i*TW +: TW], src_data[i*DW +: DW]});
      end
    end
  end

  function automatic logic [1:0] exp_ready(int m);
    return {mq[2*m+1].size() < FD && !flush, mq[2*m].size() < FD && !flush};
  endfunction

  function automatic logic [3:0] exp_cnt(int m);
    return {2'(mq[2*m+1].size()), 2'(mq[2*m].size())};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; src_valid = '0;
    tick(); tick();
    n_tests++; if (r_cv !== 1'b0 || f_cv !== 1'b0) begin n_fail++; $display("FAIL reset_valid rr=%b fp=%b want 0", r_cv, f_cv); end
    n_tests++; if (r_src !== 1'b0 || f_src !== 1'b0) begin n_fail++; $display("FAIL reset_src rr=%b fp=%b want 0", r_src, f_src); end
    n_tests++; if (r_cnt !== 4'h0 || f_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_count rr=%h fp=%h want 0", r_cnt, f_cnt); end
    n_tests++; if (r_ready !== 2'b11 || f_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready rr=%b fp=%b want 11", r_ready, f_ready); end
    n_tests++; if (r_tag !== 3'd0 || r_data !== 16'h0) begin n_fail++; $display("FAIL reset_tagdata tag=%0d data=%h want 0/0", r_tag, r_data); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    src_valid = 2'b01; src_tag = 6'd3; src_data = {16'h0, 16'h1234};
    tick();
    src_valid = '0;
    n_tests++; if (r_cv !== 1'b0 || f_cv !== 1'b0) begin n_fail++; $display("FAIL single_c1_valid rr=%b fp=%b want 0", r_cv, f_cv); end
    n_tests++; if (r_cnt !== 4'b0001) begin n_fail++; $display("FAIL single_c1_count got %b want 0001", r_cnt); end
    tick();
    n_tests++;
    if (r_cv !== 1'b1 || r_tag !== 3'd3 || r_data !== 16'h1234 || r_src !== 1'b0) begin
      n_fail++; $display("FAIL single_rr_bcast v=%b tag=%0d data=%h src=%b want 1/3/1234/0", r_cv, r_tag, r_data, r_src);
    end
    n_tests++;
    if (f_cv !== 1'b1 || f_tag !== 3'd3 || f_data !== 16'h1234 || f_src !== 1'b0) begin
      n_fail++; $display("FAIL single_fp_bcast v=%b tag=%0d data=%h src=%b want 1/3/1234/0", f_cv, f_tag, f_data, f_src);
    end
    tick();
    n_tests++; if (r_cv !== 1'b0 || f_cv !== 1'b0) begin n_fail++; $display("FAIL single_c3_valid rr=%b fp=%b want 0", r_cv, f_cv); end
  endtask

  task automatic test_rr_contention();
    int last_d [2];
    bit seen;
    logic prev;
    last_d = '{-1, -1}; seen = 0; prev = 1'b0;
    for (int c = 0; c < 14; c++) begin
      src_valid = 2'b11;
      src_tag   = {3'(c), 3'(c)};
      src_data  = {16'(c), 16'(c)};
      tick();
      n_tests++;
      if (r_cv !== m_cv[0] || r_src !== m_src[0] || r_data !== m_data[0] || r_tag !== m_tag[0]) begin
        n_fail++; $display("FAIL rr_model c=%0d got v=%b s=%b d=%h want v=%b s=%b d=%h", c, r_cv, r_src, r_data, m_cv[0], m_src[0], m_data[0]);
      end
      if (r_cv === 1'b1) begin
        n_tests++;
        if (seen && r_src === prev) begin n_fail++; $display("FAIL rr_alternate c=%0d src=%b repeated", c, r_src); end
        n_tests++;
        if (int'(r_data) <= last_d[r_src]) begin n_fail++; $display("FAIL rr_order c=%0d src=%b data=%0d after %0d", c, r_src, r_data, last_d[r_src]); end
        last_d[r_src] = int'(r_data);
        seen = 1; prev = r_src;
      end
    end
    src_valid = '0;
    repeat (5) tick();
  endtask

  task automatic test_backpressure();
    logic [18:0] sb [4][$];
    logic [1:0] er;
    logic a_cv, a_src;
    logic [18:0] got, want;
    for (int c = 0; c < 26; c++) begin
      if (c < 20) begin
        src_valid = 2'b11;
        src_tag   = 6'($urandom);
        src_data  = 32'($urandom);
      end else begin
        src_valid = '0;
      end
      for (int m = 0; m < 2; m++) begin
        er = exp_ready(m);
        n_tests++;
        if (((m == 0) ? r_ready : f_ready) !== er) begin
          n_fail++; $display("FAIL bp_ready m=%0d c=%0d got %b want %b", m, c, (m == 0) ? r_ready : f_ready, er);
        end
        for (int i = 0; i < NS; i++)
          if (src_valid[i] && er[i]) sb[2*m+i].push_back({src_tag[i*TW +: TW], src_data[i*DW +: DW]});
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        a_cv  = (m == 0) ? r_cv : f_cv;
        a_src = (m == 0) ? r_src : f_src;
        got   = (m == 0) ? {r_tag, r_data} : {f_tag, f_data};
        if (a_cv === 1'b1) begin
          n_tests++;
          if (sb[2*m+a_src].size() == 0) begin
            n_fail++; $display("FAIL bp_dup m=%0d c=%0d src=%b entry=%h not outstanding", m, c, a_src, got);
          end else begin
            want = sb[2*m+a_src].pop_front();
            if (got !== want) begin n_fail++; $display("FAIL bp_entry m=%0d c=%0d got %h want %h", m, c, got, want); end
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (sb[k].size() != 0) begin n_fail++; $display("FAIL bp_lost queue=%0d got %0d left want 0", k, sb[k].size()); end
    end
  endtask

  task automatic test_flush();
    int sum;
    src_valid = 2'b11; src_tag = {3'd6, 3'd1}; src_data = {16'hB100, 16'hA100};
    tick();
    src_tag = {3'd7, 3'd2}; src_data = {16'hB200, 16'hA200};
    tick();
    sum = int'(r_cnt[1:0]) + int'(r_cnt[3:2]);
    n_tests++; if (sum != 3) begin n_fail++; $display("FAIL flush_prequeue got %0d entries want 3", sum); end
    flush = 1'b1; src_valid = 2'b01; src_tag = {3'd0, 3'd5}; src_data = {16'h0, 16'h5555};
    #1;
    n_tests++; if (r_ready !== 2'b00 || f_ready !== 2'b00) begin n_fail++; $display("FAIL flush_ready rr=%b fp=%b want 00", r_ready, f_ready); end
    tick();
    flush = 1'b0; src_valid = '0;
    n_tests++; if (r_cv !== 1'b0 || f_cv !== 1'b0) begin n_fail++; $display("FAIL flush_valid rr=%b fp=%b want 0", r_cv, f_cv); end
    n_tests++; if (r_cnt !== 4'h0 || f_cnt !== 4'h0) begin n_fail++; $display("FAIL flush_count rr=%h fp=%h want 0", r_cnt, f_cnt); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (r_cv !== 1'b0 || f_cv !== 1'b0) begin n_fail++; $display("FAIL flush_leak c=%0d rr=%b/%0d fp=%b/%0d want no broadcast", c, r_cv, r_tag, f_cv, f_tag); end
    end
  endtask

  task automatic test_fixed_priority();
    logic        v_in [7];
    logic        e_v  [7];
    logic        e_s  [7];
    logic [2:0]  e_t  [7];
    logic [15:0] e_d  [7];
    e_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    e_t = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd0};
    e_d = '{16'h0, 16'hA001, 16'hA002, 16'hB001, 16'hA003, 16'hB002, 16'h0};
    v_in = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin src_valid = 2'b11; src_tag = {3'd4, 3'd1}; src_data = {16'hB001, 16'hA001}; end
        1: begin src_valid = 2'b11; src_tag = {3'd5, 3'd2}; src_data = {16'hB002, 16'hA002}; end
        3: begin src_valid = 2'b01; src_tag = {3'd0, 3'd3}; src_data = {16'h0, 16'hA003}; end
        default: src_valid = '0;
      endcase
      v_in[c] = src_valid[0];
      tick();
      n_tests++;
      if (f_cv !== e_v[c]) begin n_fail++; $display("FAIL fp_valid c=%0d got %b want %b", c, f_cv, e_v[c]); end
      if (e_v[c]) begin
        n_tests++;
        if (f_src !== e_s[c] || f_tag !== e_t[c] || f_data !== e_d[c]) begin
          n_fail++; $display("FAIL fp_seq c=%0d got s=%b t=%0d d=%h want s=%b t=%0d d=%h", c, f_src, f_tag, f_data, e_s[c], e_t[c], e_d[c]);
        end
      end
      n_tests++;
      if (r_cv !== m_cv[0] || r_src !== m_src[0] || r_data !== m_data[0]) begin
        n_fail++; $display("FAIL fp_rr_model c=%0d got v=%b s=%b d=%h want v=%b s=%b d=%h", c, r_cv, r_src, r_data, m_cv[0], m_src[0], m_data[0]);
      end
    end
  endtask

  task automatic test_random();
    logic        a_cv, a_src;
    logic [2:0]  a_tag;
    logic [15:0] a_data;
    logic [3:0]  a_cnt;
    for (int c = 0; c < 300; c++) begin
      src_valid = 2'($urandom);
      src_tag   = 6'($urandom);
      src_data  = 32'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      #1;
      n_tests++;
      if (r_ready !== exp_ready(0) || f_ready !== exp_ready(1)) begin
        n_fail++; $display("FAIL rand_ready c=%0d got %b/%b want %b/%b", c, r_ready, f_ready, exp_ready(0), exp_ready(1));
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        a_cv   = (m == 0) ? r_cv   : f_cv;
        a_src  = (m == 0) ? r_src  : f_src;
        a_tag  = (m == 0) ? r_tag  : f_tag;
        a_data = (m == 0) ? r_data : f_data;
        a_cnt  = (m == 0) ? r_cnt  : f_cnt;
        n_tests++;
        if (a_cv !== m_cv[m] || a_src !== m_src[m] || a_tag !== m_tag[m] || a_data !== m_data[m]) begin
          n_fail++; $display("FAIL rand_cdb m=%0d c=%0d got v=%b s=%b t=%0d d=%h want v=%b s=%b t=%0d d=%h",
                             m, c, a_cv, a_src, a_tag, a_data, m_cv[m], m_src[m], m_tag[m], m_data[m]);
        end
        n_tests++;
        if (a_cnt !== exp_cnt(m)) begin n_fail++; $display("FAIL rand_count m=%0d c=%0d got %b want %b", m, c, a_cnt, exp_cnt(m)); end
      end
    end
    rst = 1'b0; flush = 1'b0; src_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_contention();
    test_backpressure();
    test_flush();
    test_fixed_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
